// File: rtl/twos_to_signmag_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : twos_to_signmag_serial_pkg
// Description : Shared state encoding and default sizing for the serial
//               two's-complement to sign-magnitude converter.
// Revision    : 1.0 - initial release
// ============================================================================
package twos_to_signmag_serial_pkg;

  localparam int c_width_default = 32;
  localparam int c_bpc_default   = 1;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_shift = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = c_st_idle,
    ST_SHIFT = c_st_shift,
    ST_DONE  = c_st_done
  } state_t;

endpackage : twos_to_signmag_serial_pkg
`default_nettype wire

// File: rtl/twos_to_signmag_serial_slice.sv
`default_nettype none
// ============================================================================
// Module      : twos_serial_slice
// Description : One chunk of the serial negation. Bits pass through unchanged
//               up to and including the first 1, and every later bit is
//               inverted. The "seen a 1" flag ripples LSB to MSB across the
//               chunk and carries into the next chunk.
// Revision    : 1.0 - initial release
// ============================================================================
module twos_serial_slice #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [BITS_PER_CYCLE-1:0] i_bits,
  input  logic                      i_seen_one,
  output logic [BITS_PER_CYCLE-1:0] o_bits,
  output logic                      o_seen_one
);

  // w_seen[k] is the flag as it stands when bit k is processed
  logic [BITS_PER_CYCLE:0] w_seen;

  assign w_seen[0] = i_seen_one;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_bit
    assign o_bits[i]   = w_seen[i] ? ~i_bits[i] : i_bits[i];
    assign w_seen[i+1] = w_seen[i] | i_bits[i];
  end

  assign o_seen_one = w_seen[BITS_PER_CYCLE];

endmodule : twos_serial_slice
`default_nettype wire

// File: rtl/twos_to_signmag_serial.sv
`default_nettype none
// ============================================================================
// Module      : twos_to_signmag_serial
// Description : Two's-complement to sign-magnitude converter. Non-negative
//               words complete in one cycle; negative words are negated
//               serially, BITS_PER_CYCLE bits per clock, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module twos_to_signmag_serial
  import twos_to_signmag_serial_pkg::*;
#(
  parameter int WIDTH          = c_width_default,
  parameter int BITS_PER_CYCLE = c_bpc_default
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_sign_o,
  output logic [WIDTH-1:0] out_mag_o,
  output logic             busy_o
);

  localparam int c_nchunk = WIDTH / BITS_PER_CYCLE;
  localparam int c_cnt_w  = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_nchunk - 1);

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0]          r_shreg;
  logic [WIDTH-1:0]          r_acc;
  logic                      r_seen;
  logic [c_cnt_w-1:0]        r_cnt;
  logic                      r_sign;
  logic [WIDTH-1:0]          r_mag;

  logic                      w_accept;
  logic                      w_last;
  logic [BITS_PER_CYCLE-1:0] w_bits;
  logic                      w_seen_out;
  logic [WIDTH+BITS_PER_CYCLE-1:0] w_cat;
  logic [WIDTH-1:0]          w_acc_next;

  assign w_accept    = in_valid_i && (r_state == ST_IDLE);
  assign w_last      = (r_cnt == c_last);
  assign in_ready_o  = (r_state == ST_IDLE);
  assign out_valid_o = (r_state == ST_DONE);
  assign busy_o      = (r_state != ST_IDLE);
  assign out_sign_o  = r_sign;
  assign out_mag_o   = r_mag;

  twos_serial_slice #(
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_slice (
    .i_bits     (r_shreg[BITS_PER_CYCLE-1:0]),
    .i_seen_one (r_seen),
    .o_bits     (w_bits),
    .o_seen_one (w_seen_out)
  );

  // Converted chunk enters at the MSB end; the concat-then-shift form keeps
  // this legal even when a single chunk spans the whole word.
  assign w_cat      = {w_bits, r_acc} >> BITS_PER_CYCLE;
  assign w_acc_next = w_cat[WIDTH-1:0];

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid_i) begin
          w_state_next = in_data_i[WIDTH-1] ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: capture at acceptance, negate serially in SHIFT, and publish
  // the magnitude only once complete so the outputs hold their last result
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_shreg <= '0;
      r_acc   <= '0;
      r_seen  <= 1'b0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_mag   <= '0;
    end else if (w_accept) begin
      r_sign  <= in_data_i[WIDTH-1];
      r_shreg <= in_data_i;
      r_seen  <= 1'b0;
      r_cnt   <= '0;
      if (!in_data_i[WIDTH-1]) begin
        r_mag <= in_data_i;
      end
    end else if (r_state == ST_SHIFT) begin
      r_shreg <= r_shreg >> BITS_PER_CYCLE;
      r_acc   <= w_acc_next;
      r_seen  <= w_seen_out;
      r_cnt   <= r_cnt + c_cnt_w'(1);
      if (w_last) begin
        r_mag <= w_acc_next;
      end
    end
  end

endmodule : twos_to_signmag_serial
`default_nettype wire

// File: tb/tb_twos_to_signmag_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_twos_to_signmag_serial
// Description : Directed bench for the serial sign-magnitude converter, with
//               a 1-bit/cycle instance (a_*) and a 4-bit/cycle instance (b_*).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_twos_to_signmag_serial;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic         a_in_valid = 1'b0;
  logic         a_in_ready;
  logic [W-1:0] a_in_data  = '0;
  logic         a_out_valid;
  logic         a_out_ready = 1'b0;
  logic         a_sign;
  logic [W-1:0] a_mag;
  logic         a_busy;

  logic         b_in_valid = 1'b0;
  logic         b_in_ready;
  logic [W-1:0] b_in_data  = '0;
  logic         b_out_valid;
  logic         b_out_ready = 1'b1;
  logic         b_sign;
  logic [W-1:0] b_mag;
  logic         b_busy;

  twos_to_signmag_serial #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut_a (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .in_valid_i  (a_in_valid),
    .in_ready_o  (a_in_ready),
    .in_data_i   (a_in_data),
    .out_valid_o (a_out_valid),
    .out_ready_i (a_out_ready),
    .out_sign_o  (a_sign),
    .out_mag_o   (a_mag),
    .busy_o      (a_busy)
  );

  twos_to_signmag_serial #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut_b (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .in_valid_i  (b_in_valid),
    .in_ready_o  (b_in_ready),
    .in_data_i   (b_in_data),
    .out_valid_o (b_out_valid),
    .out_ready_i (b_out_ready),
    .out_sign_o  (b_sign),
    .out_mag_o   (b_mag),
    .busy_o      (b_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word for one edge, then count edges (acceptance edge = 1)
  // until out_valid is seen, bounded by a cycle budget.
  task automatic run_a(input logic [W-1:0] d, output int lat);
    a_in_data  = d;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_b(input logic [W-1:0] d, output int lat);
    b_in_data  = d;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  function automatic logic [W-1:0] ref_mag(input logic [W-1:0] d);
    return d[W-1] ? (~d + 32'd1) : d;
  endfunction

  logic [W-1:0] vec_in  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF};
  logic [W-1:0] vec_mag [4] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h7FFF_FFFF};
  logic         vec_sgn [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  int           vec_lat [4] = '{33, 33, 1, 1};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    int           spurious;
    logic [W-1:0] d;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_in_ready",  a_in_ready,  1'b1);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_sign",      a_sign,      1'b0);
    check("rst_mag",       a_mag,       32'h0);
    check("rst_busy",      a_busy,      1'b0);
    rst_n = 1'b1;
    tick();

    // Positive word, consumer not ready yet
    a_out_ready = 1'b0;
    check("pos_ready", a_in_ready, 1'b1);
    run_a(32'h0000_0005, lat);
    check("pos_lat",  lat,    32'd1);
    check("pos_sign", a_sign, 1'b0);
    check("pos_mag",  a_mag,  32'h0000_0005);
    a_out_ready = 1'b1;
    tick();
    check("pos_busy_after",  a_busy,      1'b0);
    check("pos_valid_after", a_out_valid, 1'b0);

    // -5 with consumer always ready: one-cycle valid pulse
    run_a(32'hFFFF_FFFB, lat);
    check("neg5_lat",  lat,    32'd33);
    check("neg5_sign", a_sign, 1'b1);
    check("neg5_mag",  a_mag,  32'h0000_0005);
    tick();
    check("neg5_pulse_one_cycle", a_out_valid, 1'b0);

    // Boundary words
    for (int i = 0; i < 4; i++) begin
      run_a(vec_in[i], lat);
      check("vec_lat",  lat,    vec_lat[i]);
      check("vec_sign", a_sign, vec_sgn[i]);
      check("vec_mag",  a_mag,  vec_mag[i]);
      tick();
    end

    // Backpressure: hold DONE for 10 cycles with stray in_valid pulses
    a_out_ready = 1'b0;
    run_a(32'hFFFF_FF00, lat);
    check("bp_lat", lat, 32'd33);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid",    a_out_valid, 1'b1);
      check("bp_in_ready", a_in_ready,  1'b0);
      check("bp_sign",     a_sign,      1'b1);
      check("bp_mag",      a_mag,       32'h0000_0100);
      a_in_valid = i[0];
      a_in_data  = 32'h0000_1234;
      tick();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    check("bp_idle_ready", a_in_ready,  1'b1);
    check("bp_idle_valid", a_out_valid, 1'b0);
    check("bp_hold_mag",   a_mag,       32'h0000_0100);
    check("bp_hold_sign",  a_sign,      1'b1);
    repeat (3) tick();
    check("bp_no_stray_op", a_busy, 1'b0);

    // Reset in the middle of SHIFT (chunk 12 of -5)
    a_in_data  = 32'hFFFF_FFFB;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (12) tick();
    check("abort_busy_before", a_busy, 1'b1);
    rst_n = 1'b0;
    tick();
    check("abort_busy",  a_busy,      1'b0);
    check("abort_ready", a_in_ready,  1'b1);
    check("abort_valid", a_out_valid, 1'b0);
    check("abort_mag",   a_mag,       32'h0);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_out_valid) spurious++;
      tick();
    end
    check("abort_no_result", spurious, 32'd0);
    run_a(32'hFFFF_FF9C, lat);
    check("neg100_lat",  lat,    32'd33);
    check("neg100_sign", a_sign, 1'b1);
    check("neg100_mag",  a_mag,  32'd100);
    tick();

    // Four bits per cycle
    run_b(32'hFFFF_FFFB, lat);
    check("b_neg5_lat", lat,    32'd9);
    check("b_neg5_mag", b_mag,  32'h0000_0005);
    tick();
    run_b(32'h8000_0000, lat);
    check("b_min_mag", b_mag, 32'h8000_0000);
    tick();
    for (int i = 0; i < 1000; i++) begin
      d = $urandom;
      run_b(d, lat);
      check("b_rand_lat",  lat,    d[W-1] ? 32'd9 : 32'd1);
      check("b_rand_sign", b_sign, d[W-1]);
      check("b_rand_mag",  b_mag,  ref_mag(d));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_twos_to_signmag_serial
`default_nettype wire
